// File: rtl/ht_cmd_client.sv
// -----------------------------------------------------------------------------
// hash_table package : key/value widths and the command/result types shared by
//                      the hash table engine and its clients.
// ht_cmd_client      : host-side initiator for the hash table engine.
//   Accepts host requests and forwards them as ht_command_t (valid/ready). Each
//   returned ht_result_t is checked in order against the {key, opcode} that was
//   recorded when its command was accepted, and is then returned to the host as
//   a response. The block also tracks outstanding commands, flags ordering
//   mismatches and result timeouts, and runs a drain/flush sequence.
//
// Ports
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   req_*_i / req_ready_o          host request channel (key, value, opcode)
//   cmd_o / cmd_valid_o / cmd_ready_i          command to the hash table
//   result_i / result_valid_i / result_ready_o result from the hash table
//   resp_*_o / resp_valid_o / resp_ready_i     response to the host
//   flush_i / flush_done_o         drain request (level) / 1-cycle completion pulse
//   outstanding_o                  commands accepted but not yet resulted
//   err_mismatch_o                 1-cycle pulse on a mismatched or unexpected result
//   err_timeout_o                  sticky result-timeout flag
//   mismatch_cnt_o                 saturating count of mismatch events
// -----------------------------------------------------------------------------
package hash_table;
   localparam int KEY_WIDTH   = 16;
   localparam int VALUE_WIDTH = 16;

   typedef enum logic [1:0] {
      OP_SEARCH = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2
   } ht_opcode_t;

   typedef enum logic [1:0] {
      RES_FOUND     = 2'd0,
      RES_NOT_FOUND = 2'd1,
      RES_SUCCESS   = 2'd2,
      RES_FAIL      = 2'd3
   } ht_rescode_t;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]   key;
      logic [VALUE_WIDTH-1:0] value;
      ht_opcode_t             opcode;
   } ht_command_t;

   typedef struct packed {
      ht_command_t            cmd;
      ht_rescode_t            rescode;
      logic [VALUE_WIDTH-1:0] found_value;
   } ht_result_t;
endpackage

module ht_cmd_client
   import hash_table::*;
#(
   parameter int MAX_OUTSTANDING = 8,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_n_i,
   input  logic [KEY_WIDTH-1:0]               req_key_i,
   input  logic [VALUE_WIDTH-1:0]             req_value_i,
   input  ht_opcode_t                         req_opcode_i,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   output ht_command_t                        cmd_o,
   output logic                               cmd_valid_o,
   input  logic                               cmd_ready_i,
   input  ht_result_t                         result_i,
   input  logic                               result_valid_i,
   output logic                               result_ready_o,
   output logic [KEY_WIDTH-1:0]               resp_key_o,
   output logic [VALUE_WIDTH-1:0]             resp_value_o,
   output ht_rescode_t                        resp_rescode_o,
   output logic                               resp_valid_o,
   input  logic                               resp_ready_i,
   input  logic                               flush_i,
   output logic                               flush_done_o,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
   output logic                               err_mismatch_o,
   output logic                               err_timeout_o,
   output logic [CNT_WIDTH-1:0]               mismatch_cnt_o
);

   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int OUT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef struct packed {
      logic [KEY_WIDTH-1:0] key;
      ht_opcode_t           opcode;
   } tag_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                   state_q,        state_d;
   ht_command_t              cmd_q,          cmd_d;
   logic                     cmd_valid_q,    cmd_valid_d;
   tag_t                     tag_mem_q [MAX_OUTSTANDING];
   tag_t                     tag_mem_d [MAX_OUTSTANDING];
   logic [PTR_W-1:0]         wr_ptr_q,       wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q,       rd_ptr_d;
   logic [OUT_W-1:0]         outstanding_q,  outstanding_d;
   logic [KEY_WIDTH-1:0]     resp_key_q,     resp_key_d;
   logic [VALUE_WIDTH-1:0]   resp_value_q,   resp_value_d;
   ht_rescode_t              resp_rescode_q, resp_rescode_d;
   logic                     resp_valid_q,   resp_valid_d;
   logic                     err_mismatch_q, err_mismatch_d;
   logic                     err_timeout_q,  err_timeout_d;
   logic [CNT_WIDTH-1:0]     mismatch_cnt_q, mismatch_cnt_d;
   logic [TMR_W-1:0]         timer_q,        timer_d;
   logic                     flush_done_q,   flush_done_d;

   logic req_acc;
   logic res_acc;
   logic pop;
   logic mismatch_evt;
   tag_t head_tag;

   assign req_ready_o    = (state_q == ST_RUN) && (!cmd_valid_q || cmd_ready_i) &&
                           (outstanding_q < OUT_W'(MAX_OUTSTANDING));
   assign result_ready_o = !resp_valid_q || resp_ready_i;

   assign req_acc  = req_valid_i && req_ready_o;
   assign res_acc  = result_valid_i && result_ready_o;
   // A result arriving with nothing outstanding has no tag to match; it is dropped.
   assign pop      = res_acc && (outstanding_q != '0);
   assign head_tag = tag_mem_q[rd_ptr_q];

   always_comb begin
      cmd_d          = cmd_q;
      cmd_valid_d    = cmd_valid_q;
      tag_mem_d      = tag_mem_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      outstanding_d  = outstanding_q;
      resp_key_d     = resp_key_q;
      resp_value_d   = resp_value_q;
      resp_rescode_d = resp_rescode_q;
      resp_valid_d   = resp_valid_q;
      mismatch_evt   = 1'b0;
      state_d        = state_q;
      flush_done_d   = 1'b0;

      // Command register: cleared on handshake, reloaded on a new accept.
      if (cmd_valid_q && cmd_ready_i) begin
         cmd_valid_d = 1'b0;
      end
      if (req_acc) begin
         cmd_d.key               = req_key_i;
         cmd_d.value             = req_value_i;
         cmd_d.opcode            = req_opcode_i;
         cmd_valid_d             = 1'b1;
         tag_mem_d[wr_ptr_q].key    = req_key_i;
         tag_mem_d[wr_ptr_q].opcode = req_opcode_i;
         wr_ptr_d                = wr_ptr_q + PTR_W'(1);
      end

      // Response register: same hold/reload pattern on the host side.
      if (resp_valid_q && resp_ready_i) begin
         resp_valid_d = 1'b0;
      end
      if (res_acc) begin
         if (pop) begin
            rd_ptr_d       = rd_ptr_q + PTR_W'(1);
            resp_key_d     = result_i.cmd.key;
            resp_value_d   = (result_i.cmd.opcode == OP_SEARCH) ? result_i.found_value
                                                                 : result_i.cmd.value;
            resp_rescode_d = result_i.rescode;
            resp_valid_d   = 1'b1;
            if ((head_tag.key != result_i.cmd.key) || (head_tag.opcode != result_i.cmd.opcode)) begin
               mismatch_evt = 1'b1;
            end
         end else begin
            mismatch_evt = 1'b1;
         end
      end

      case ({req_acc, pop})
         2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
         2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase

      err_mismatch_d = mismatch_evt;
      mismatch_cnt_d = mismatch_cnt_q;
      if (mismatch_evt && (mismatch_cnt_q != '1)) begin
         mismatch_cnt_d = mismatch_cnt_q + CNT_WIDTH'(1);
      end

      timer_d = timer_q;
      if ((outstanding_q == '0) || res_acc) begin
         timer_d = '0;
      end else if (timer_q < TMR_W'(TIMEOUT_CYCLES)) begin
         timer_d = timer_q + TMR_W'(1);
      end
      err_timeout_d = err_timeout_q || (timer_d == TMR_W'(TIMEOUT_CYCLES));

      case (state_q)
         ST_RUN: begin
            if (flush_i) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((outstanding_q == '0) && !cmd_valid_q && !resp_valid_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      // Registered pulse: high exactly while the FSM sits in DONE.
      flush_done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q        <= ST_RUN;
         cmd_q          <= '0;
         cmd_valid_q    <= 1'b0;
         tag_mem_q      <= '{default: '0};
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         outstanding_q  <= '0;
         resp_key_q     <= '0;
         resp_value_q   <= '0;
         resp_rescode_q <= RES_FOUND;
         resp_valid_q   <= 1'b0;
         err_mismatch_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         mismatch_cnt_q <= '0;
         timer_q        <= '0;
         flush_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cmd_q          <= cmd_d;
         cmd_valid_q    <= cmd_valid_d;
         tag_mem_q      <= tag_mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         outstanding_q  <= outstanding_d;
         resp_key_q     <= resp_key_d;
         resp_value_q   <= resp_value_d;
         resp_rescode_q <= resp_rescode_d;
         resp_valid_q   <= resp_valid_d;
         err_mismatch_q <= err_mismatch_d;
         err_timeout_q  <= err_timeout_d;
         mismatch_cnt_q <= mismatch_cnt_d;
         timer_q        <= timer_d;
         flush_done_q   <= flush_done_d;
      end
   end

   assign cmd_o          = cmd_q;
   assign cmd_valid_o    = cmd_valid_q;
   assign resp_key_o     = resp_key_q;
   assign resp_value_o   = resp_value_q;
   assign resp_rescode_o = resp_rescode_q;
   assign resp_valid_o   = resp_valid_q;
   assign flush_done_o   = flush_done_q;
   assign outstanding_o  = outstanding_q;
   assign err_mismatch_o = err_mismatch_q;
   assign err_timeout_o  = err_timeout_q;
   assign mismatch_cnt_o = mismatch_cnt_q;

endmodule

// File: tb/tb_ht_cmd_client.sv
// -----------------------------------------------------------------------------
// Directed testbench for ht_cmd_client. The bench plays both the host and the
// hash table engine; every expected value is written out by hand.
// -----------------------------------------------------------------------------
module tb_ht_cmd_client;
   import hash_table::*;

   logic                   clk = 1'b0;
   logic                   rst_n_i;
   logic [KEY_WIDTH-1:0]   req_key_i;
   logic [VALUE_WIDTH-1:0] req_value_i;
   ht_opcode_t             req_opcode_i;
   logic                   req_valid_i;
   logic                   req_ready_o;
   ht_command_t            cmd_o;
   logic                   cmd_valid_o;
   logic                   cmd_ready_i;
   ht_result_t             result_i;
   logic                   result_valid_i;
   logic                   result_ready_o;
   logic [KEY_WIDTH-1:0]   resp_key_o;
   logic [VALUE_WIDTH-1:0] resp_value_o;
   ht_rescode_t            resp_rescode_o;
   logic                   resp_valid_o;
   logic                   resp_ready_i;
   logic                   flush_i;
   logic                   flush_done_o;
   logic [3:0]             outstanding_o;
   logic                   err_mismatch_o;
   logic                   err_timeout_o;
   logic [15:0]            mismatch_cnt_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ht_cmd_client #(
      .MAX_OUTSTANDING (8),
      .TIMEOUT_CYCLES  (1024),
      .CNT_WIDTH       (16)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n_i),
      .req_key_i      (req_key_i),
      .req_value_i    (req_value_i),
      .req_opcode_i   (req_opcode_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .cmd_o          (cmd_o),
      .cmd_valid_o    (cmd_valid_o),
      .cmd_ready_i    (cmd_ready_i),
      .result_i       (result_i),
      .result_valid_i (result_valid_i),
      .result_ready_o (result_ready_o),
      .resp_key_o     (resp_key_o),
      .resp_value_o   (resp_value_o),
      .resp_rescode_o (resp_rescode_o),
      .resp_valid_o   (resp_valid_o),
      .resp_ready_i   (resp_ready_i),
      .flush_i        (flush_i),
      .flush_done_o   (flush_done_o),
      .outstanding_o  (outstanding_o),
      .err_mismatch_o (err_mismatch_o),
      .err_timeout_o  (err_timeout_o),
      .mismatch_cnt_o (mismatch_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_valid_i    = 1'b0;
      req_key_i      = '0;
      req_value_i    = '0;
      req_opcode_i   = OP_SEARCH;
      result_valid_i = 1'b0;
      result_i       = '0;
      cmd_ready_i    = 1'b1;
      resp_ready_i   = 1'b1;
      flush_i        = 1'b0;
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n_i = 1'b1;
      tick();
   endtask

   // Called and returns on a negedge; the accept edge lies in between.
   task automatic send_req(input logic [15:0] k, input logic [15:0] v, input ht_opcode_t op);
      req_key_i    = k;
      req_value_i  = v;
      req_opcode_i = op;
      req_valid_i  = 1'b1;
      #1;
      for (int n = 0; n < 50 && !req_ready_o; n++) begin
         tick();
         #1;
      end
      if (!req_ready_o) chk("req_wait", 64'(req_ready_o), 64'd1);
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic send_res(input logic [15:0] k, input logic [15:0] v, input ht_opcode_t op,
                           input ht_rescode_t rc, input logic [15:0] fv);
      result_i.cmd.key     = k;
      result_i.cmd.value   = v;
      result_i.cmd.opcode  = op;
      result_i.rescode     = rc;
      result_i.found_value = fv;
      result_valid_i       = 1'b1;
      #1;
      for (int n = 0; n < 50 && !result_ready_o; n++) begin
         tick();
         #1;
      end
      if (!result_ready_o) chk("res_wait", 64'(result_ready_o), 64'd1);
      tick();
      result_valid_i = 1'b0;
   endtask

   int          issued;
   int          res_idx;
   int          resp_cnt;
   int          done_cnt;
   logic        cmd_stable, resp_stable, order_ok, no_new;
   logic        prev_cv, prev_cr, prev_rv, prev_rr;
   ht_command_t prev_cmd;
   logic [15:0] prev_rk, prev_rval;

   initial begin
      rst_n_i = 1'b0;
      idle_inputs();
      tick();
      tick();
      // Reset state
      chk("rst_cmd_valid",    64'(cmd_valid_o), 64'd0);
      chk("rst_resp_valid",   64'(resp_valid_o), 64'd0);
      chk("rst_flush_done",   64'(flush_done_o), 64'd0);
      chk("rst_err_mismatch", 64'(err_mismatch_o), 64'd0);
      chk("rst_err_timeout",  64'(err_timeout_o), 64'd0);
      chk("rst_outstanding",  64'(outstanding_o), 64'd0);
      chk("rst_mismatch_cnt", 64'(mismatch_cnt_o), 64'd0);
      rst_n_i = 1'b1;
      tick();
      chk("rst_req_ready",    64'(req_ready_o), 64'd1);
      chk("rst_result_ready", 64'(result_ready_o), 64'd1);

      // 1: single SEARCH, one-cycle latency, command held under backpressure
      cmd_ready_i = 1'b0;
      send_req(16'h1234, 16'h0000, OP_SEARCH);
      chk("t1_cmd_valid",   64'(cmd_valid_o), 64'd1);
      chk("t1_cmd_key",     64'(cmd_o.key), 64'h1234);
      chk("t1_cmd_opcode",  64'(cmd_o.opcode), 64'(OP_SEARCH));
      chk("t1_outstanding", 64'(outstanding_o), 64'd1);
      chk("t1_req_blocked", 64'(req_ready_o), 64'd0);
      tick();
      chk("t1_cmd_hold",    64'(cmd_valid_o), 64'd1);
      cmd_ready_i = 1'b1;
      tick();
      chk("t1_cmd_taken",   64'(cmd_valid_o), 64'd0);
      send_res(16'h1234, 16'h0000, OP_SEARCH, RES_FOUND, 16'h00AB);
      chk("t1_resp_valid",  64'(resp_valid_o), 64'd1);
      chk("t1_resp_key",    64'(resp_key_o), 64'h1234);
      chk("t1_resp_value",  64'(resp_value_o), 64'h00AB);
      chk("t1_resp_rc",     64'(resp_rescode_o), 64'(RES_FOUND));
      chk("t1_no_mismatch", 64'(err_mismatch_o), 64'd0);
      chk("t1_out_zero",    64'(outstanding_o), 64'd0);
      tick();
      chk("t1_resp_taken",  64'(resp_valid_o), 64'd0);

      // 2: FIFO full blocks requests; one result reopens them next cycle
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send_req(16'(16'h0010 + i), 16'(16'h0100 + i), OP_INSERT);
      end
      chk("t2_outstanding8", 64'(outstanding_o), 64'd8);
      chk("t2_req_full",     64'(req_ready_o), 64'd0);
      chk("t2_result_open",  64'(result_ready_o), 64'd1);
      send_res(16'h0010, 16'h0100, OP_INSERT, RES_SUCCESS, 16'hFFFF);
      chk("t2_outstanding7", 64'(outstanding_o), 64'd7);
      chk("t2_req_reopen",   64'(req_ready_o), 64'd1);
      chk("t2_insert_value", 64'(resp_value_o), 64'h0100);
      chk("t2_insert_rc",    64'(resp_rescode_o), 64'(RES_SUCCESS));
      for (int i = 1; i < 8; i++) begin
         send_res(16'(16'h0010 + i), 16'(16'h0100 + i), OP_INSERT, RES_SUCCESS, 16'h0000);
      end
      chk("t2_drained",      64'(outstanding_o), 64'd0);
      chk("t2_last_key",     64'(resp_key_o), 64'h0017);
      chk("t2_no_mismatch",  64'(mismatch_cnt_o), 64'd0);

      // 3: results returned in swapped order
      do_reset();
      send_req(16'h0001, 16'h0000, OP_SEARCH);
      send_req(16'h0002, 16'h0000, OP_SEARCH);
      send_res(16'h0002, 16'h0000, OP_SEARCH, RES_NOT_FOUND, 16'h0000);
      chk("t3_err_first",   64'(err_mismatch_o), 64'd1);
      chk("t3_cnt_first",   64'(mismatch_cnt_o), 64'd1);
      chk("t3_resp_first",  64'(resp_valid_o), 64'd1);
      chk("t3_key_first",   64'(resp_key_o), 64'h0002);
      send_res(16'h0001, 16'h0000, OP_SEARCH, RES_NOT_FOUND, 16'h0000);
      chk("t3_err_second",  64'(err_mismatch_o), 64'd1);
      chk("t3_cnt_second",  64'(mismatch_cnt_o), 64'd2);
      chk("t3_key_second",  64'(resp_key_o), 64'h0001);
      tick();
      chk("t3_err_pulse",   64'(err_mismatch_o), 64'd0);
      chk("t3_cnt_hold",    64'(mismatch_cnt_o), 64'd2);
      chk("t3_out_zero",    64'(outstanding_o), 64'd0);

      // 4: unexpected result with nothing outstanding
      do_reset();
      send_res(16'h0055, 16'h0000, OP_DELETE, RES_SUCCESS, 16'h0000);
      chk("t4_no_resp",     64'(resp_valid_o), 64'd0);
      chk("t4_err",         64'(err_mismatch_o), 64'd1);
      chk("t4_cnt",         64'(mismatch_cnt_o), 64'd1);
      chk("t4_out_zero",    64'(outstanding_o), 64'd0);

      // 6: flush with backpressure; data held stable while stalled
      do_reset();
      resp_ready_i = 1'b0;
      issued       = 0;
      cmd_stable   = 1'b1;
      prev_cv      = 1'b0;
      prev_cr      = 1'b0;
      prev_cmd     = '0;
      for (int n = 0; n < 100 && !(issued == 3 && !cmd_valid_o); n++) begin
         if (prev_cv && !prev_cr && (!cmd_valid_o || cmd_o !== prev_cmd)) cmd_stable = 1'b0;
         cmd_ready_i = 1'($urandom_range(0, 1));
         if (issued < 3) begin
            req_valid_i  = 1'b1;
            req_key_i    = 16'(16'h00A0 + issued);
            req_value_i  = '0;
            req_opcode_i = OP_SEARCH;
         end else begin
            req_valid_i  = 1'b0;
         end
         #1;
         if (req_valid_i && req_ready_o) issued++;
         prev_cv  = cmd_valid_o;
         prev_cr  = cmd_ready_i;
         prev_cmd = cmd_o;
         tick();
      end
      req_valid_i = 1'b0;
      cmd_ready_i = 1'b1;
      chk("t6_issued",      64'(issued), 64'd3);
      chk("t6_cmd_stable",  64'(cmd_stable), 64'd1);
      chk("t6_out3",        64'(outstanding_o), 64'd3);

      flush_i = 1'b1;
      tick();
      req_valid_i  = 1'b1;
      req_key_i    = 16'hBEEF;
      req_opcode_i = OP_INSERT;
      res_idx      = 0;
      resp_cnt     = 0;
      done_cnt     = 0;
      resp_stable  = 1'b1;
      order_ok     = 1'b1;
      no_new       = 1'b1;
      prev_rv      = 1'b0;
      prev_rr      = 1'b0;
      prev_rk      = '0;
      prev_rval    = '0;
      for (int n = 0; n < 200; n++) begin
         if (cmd_valid_o) no_new = 1'b0;
         if (prev_rv && !prev_rr &&
             (!resp_valid_o || resp_key_o !== prev_rk || resp_value_o !== prev_rval)) resp_stable = 1'b0;
         if (flush_done_o) begin
            done_cnt++;
            flush_i     = 1'b0;
            req_valid_i = 1'b0;
         end
         resp_ready_i = (n < 20) ? 1'b0 : 1'($urandom_range(0, 1));
         if (res_idx < 3) begin
            result_valid_i       = 1'b1;
            result_i.cmd.key     = 16'(16'h00A0 + res_idx);
            result_i.cmd.value   = '0;
            result_i.cmd.opcode  = OP_SEARCH;
            result_i.rescode     = RES_FOUND;
            result_i.found_value = 16'(16'h0500 + res_idx);
         end else begin
            result_valid_i       = 1'b0;
         end
         #1;
         if (n == 19) begin
            chk("t6_stall_out2",    64'(outstanding_o), 64'd2);
            chk("t6_stall_no_resp", 64'(resp_cnt), 64'd0);
            chk("t6_stall_req_blk", 64'(req_ready_o), 64'd0);
            chk("t6_stall_no_done", 64'(done_cnt), 64'd0);
         end
         if (result_valid_i && result_ready_o) res_idx++;
         if (resp_valid_o && resp_ready_i) begin
            if (resp_key_o !== 16'(16'h00A0 + resp_cnt) || resp_value_o !== 16'(16'h0500 + resp_cnt))
               order_ok = 1'b0;
            resp_cnt++;
         end
         prev_rv   = resp_valid_o;
         prev_rr   = resp_ready_i;
         prev_rk   = resp_key_o;
         prev_rval = resp_value_o;
         tick();
      end
      result_valid_i = 1'b0;
      resp_ready_i   = 1'b1;
      flush_i        = 1'b0;
      req_valid_i    = 1'b0;
      chk("t6_done_once",   64'(done_cnt), 64'd1);
      chk("t6_resp_count",  64'(resp_cnt), 64'd3);
      chk("t6_resp_order",  64'(order_ok), 64'd1);
      chk("t6_resp_stable", 64'(resp_stable), 64'd1);
      chk("t6_no_new_cmd",  64'(no_new), 64'd1);
      chk("t6_out_zero",    64'(outstanding_o), 64'd0);
      chk("t6_no_mismatch", 64'(mismatch_cnt_o), 64'd0);

      // 5: timeout sets after TIMEOUT_CYCLES and stays set
      do_reset();
      send_req(16'h0077, 16'h0000, OP_SEARCH);
      for (int n = 0; n < 1000; n++) tick();
      chk("t5_not_yet",     64'(err_timeout_o), 64'd0);
      for (int n = 0; n < 100 && !err_timeout_o; n++) tick();
      chk("t5_timeout",     64'(err_timeout_o), 64'd1);
      send_res(16'h0077, 16'h0000, OP_SEARCH, RES_FOUND, 16'h0042);
      chk("t5_resp_value",  64'(resp_value_o), 64'h0042);
      tick();
      tick();
      chk("t5_sticky",      64'(err_timeout_o), 64'd1);
      chk("t5_out_zero",    64'(outstanding_o), 64'd0);

      // Reset mid-operation: in-flight command forgotten, late result unexpected
      send_req(16'h0099, 16'h0000, OP_SEARCH);
      chk("rm_out1",        64'(outstanding_o), 64'd1);
      do_reset();
      chk("rm_out_clear",   64'(outstanding_o), 64'd0);
      chk("rm_timeout_clr", 64'(err_timeout_o), 64'd0);
      send_res(16'h0099, 16'h0000, OP_SEARCH, RES_FOUND, 16'h0000);
      chk("rm_no_resp",     64'(resp_valid_o), 64'd0);
      chk("rm_err",         64'(err_mismatch_o), 64'd1);
      chk("rm_cnt",         64'(mismatch_cnt_o), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
